// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit positions,
// scan state encodings and the hex-to-segment decode table.
package smg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    DRIVE    = 2'd1,
    GAP      = 2'd2
  } scan_state_e;

  // Active-high {g,f,e,d,c,b,a}; polarity is applied by the driver.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/smg_prescaler.sv
// Modulo-DIV counter with a registered wrap flag that is high exactly while
// the count sits at DIV-1; a synchronous clear restarts it at zero.
module smg_prescaler #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  output logic wrap
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= (count == CW'(DIV - 1)) ? '0 : count + 1'b1;
      // Predict the terminal count one cycle early so wrap comes straight off a flop.
      wrap  <= (count == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/smg_scan_driver.sv
// Multiplexed seven-segment scan driver with anti-ghost gap, leading-zero
// blanking, frame-boundary value capture and a free-running step tick.
module smg_scan_driver
  import smg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GAP_CYC     = 16,
  parameter int TICK_DIV    = 10000000,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [4*DIGITS-1:0]   Number_Sig,
  input  logic [DIGITS-1:0]     Dp_Sig,
  input  logic                  Blank_LZ,
  input  logic                  Load,
  output logic [7:0]            SMG_Data,
  output logic [DIGITS-1:0]     Scan_Sig,
  output logic                  Frame_Done,
  output logic                  Step_Tick
);

  localparam int                DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0]     LAST    = DW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  scan_state_e         state, state_nxt;
  logic [DW-1:0]       digit, digit_nxt, digit_inc;
  logic                scan_wrap, gap_end, step, enter_d0, capture;
  logic [4*DIGITS-1:0] disp_num, num_nxt;
  logic [DIGITS-1:0]   disp_dp, dp_nxt, sel_ah;
  logic                disp_blz, blz_nxt, pending;
  logic [3:0]          nib;
  logic                any_nz, blank;
  logic [7:0]          seg_ah;

  // The scan prescaler times RST_WAIT and DRIVE; it idles cleared during GAP.
  smg_prescaler #(.DIV(SCAN_DIV)) u_scan_pre (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (state == GAP),
    .wrap (scan_wrap)
  );

  if (GAP_CYC >= 2) begin : g_gap_pre
    smg_prescaler #(.DIV(GAP_CYC)) u_gap_pre (
      .CLK  (CLK),
      .RSTn (RSTn),
      .clr  (state != GAP),
      .wrap (gap_end)
    );
  end else begin : g_gap_single
    assign gap_end = 1'b1;
  end

  smg_prescaler #(.DIV(TICK_DIV)) u_tick_pre (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (1'b0),
    .wrap (Step_Tick)
  );

  assign digit_inc = (digit == LAST) ? '0 : digit + 1'b1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    step      = 1'b0;
    unique case (state)
      RST_WAIT: if (scan_wrap) begin
        state_nxt = DRIVE;
        digit_nxt = '0;
        step      = 1'b1;
      end
      DRIVE: if (scan_wrap) begin
        step = 1'b1;
        if (GAP_CYC == 0) digit_nxt = digit_inc;
        else              state_nxt = GAP;
      end
      GAP: if (gap_end) begin
        step      = 1'b1;
        state_nxt = DRIVE;
        digit_nxt = digit_inc;
      end
      default: state_nxt = RST_WAIT;
    endcase
  end

  assign enter_d0 = step && (state_nxt == DRIVE) && (digit_nxt == '0);
  assign capture  = enter_d0 && (pending || Load);
  assign num_nxt  = capture ? Number_Sig : disp_num;
  assign dp_nxt   = capture ? Dp_Sig     : disp_dp;
  assign blz_nxt  = capture ? Blank_LZ   : disp_blz;

  assign Frame_Done = (GAP_CYC == 0) ? (state == DRIVE && digit == LAST && scan_wrap)
                                     : (state == GAP   && digit == LAST && gap_end);

  // Decode from the post-capture value so DRIVE(0) already shows a freshly latched frame.
  always_comb begin
    nib    = num_nxt[int'(digit_nxt)*4 +: 4];
    any_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(digit_nxt) && num_nxt[4*i +: 4] != 4'h0) any_nz = 1'b1;
    end
    blank          = blz_nxt && (digit_nxt != '0) && !any_nz;
    seg_ah         = 8'h00;
    seg_ah[SEG_DP] = dp_nxt[digit_nxt];
    if (!blank) seg_ah[SEG_G:SEG_A] = hex_to_seg(nib);
    sel_ah            = '0;
    sel_ah[digit_nxt] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RST_WAIT;
      digit    <= '0;
      disp_num <= '0;
      disp_dp  <= '0;
      disp_blz <= 1'b0;
      pending  <= 1'b0;
      SMG_Data <= SEG_OFF;
      Scan_Sig <= DIG_OFF;
    end else begin
      state    <= state_nxt;
      digit    <= digit_nxt;
      disp_num <= num_nxt;
      disp_dp  <= dp_nxt;
      disp_blz <= blz_nxt;
      pending  <= enter_d0 ? 1'b0 : (pending | Load);
      if (state_nxt == DRIVE) begin
        SMG_Data <= seg_ah ^ SEG_OFF;
        Scan_Sig <= sel_ah ^ DIG_OFF;
      end else begin
        SMG_Data <= SEG_OFF;
        Scan_Sig <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed bench for smg_scan_driver with DIGITS=4, SCAN_DIV=4, GAP_CYC=2, TICK_DIV=5, active-low.
// cyc counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_smg_scan_driver;

  logic        CLK;
  logic        RSTn;
  logic [15:0] Number_Sig;
  logic [3:0]  Dp_Sig;
  logic        Blank_LZ;
  logic        Load;
  logic [7:0]  SMG_Data;
  logic [3:0]  Scan_Sig;
  logic        Frame_Done;
  logic        Step_Tick;

  int cyc;
  int checks = 0;
  int fails  = 0;

  smg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .GAP_CYC(2), .TICK_DIV(5), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Number_Sig (Number_Sig),
    .Dp_Sig     (Dp_Sig),
    .Blank_LZ   (Blank_LZ),
    .Load       (Load),
    .SMG_Data   (SMG_Data),
    .Scan_Sig   (Scan_Sig),
    .Frame_Done (Frame_Done),
    .Step_Tick  (Step_Tick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic goto(input int n);
    for (int i = 0; i < 100 && cyc < n; i++) @(negedge CLK);
    if (cyc != n) begin
      checks++; fails++;
      $display("FAIL goto: cycle=%0d expected %0d", cyc, n);
    end
  endtask

  task automatic do_reset(input logic [15:0] num, input logic [3:0] dp, input logic blz, input logic ld);
    RSTn = 1'b0;
    Load = 1'b0;
    repeat (2) @(negedge CLK);
    Number_Sig = num;
    Dp_Sig     = dp;
    Blank_LZ   = blz;
    RSTn       = 1'b1;
    if (ld) begin
      Load = 1'b1;
      @(negedge CLK);
      Load = 1'b0;
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; Load = 1'b0; Number_Sig = '0; Dp_Sig = '0; Blank_LZ = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (SMG_Data !== 8'hFF) begin fails++; $display("FAIL reset_seg: got %h expected ff", SMG_Data); end
    checks++; if (Scan_Sig !== 4'hF) begin fails++; $display("FAIL reset_scan: got %h expected f", Scan_Sig); end
    checks++; if (Step_Tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", Step_Tick); end
    checks++; if (Frame_Done !== 1'b0) begin fails++; $display("FAIL reset_frame: got %b expected 0", Frame_Done); end
    do_reset(16'h1234, 4'b0000, 1'b0, 1'b1);
    goto(3);
    checks++;
    if ({Scan_Sig, SMG_Data} !== 12'hF_FF) begin
      fails++; $display("FAIL rst_wait_off: got %h/%h expected f/ff", Scan_Sig, SMG_Data);
    end
  endtask

  task automatic test_display_1234();
    logic [11:0] exp_seq [0:5];
    exp_seq = '{12'hE_99, 12'hE_99, 12'hE_99, 12'hE_99, 12'hF_FF, 12'hF_FF};
    for (int n = 4; n <= 9; n++) begin
      goto(n);
      checks++;
      if ({Scan_Sig, SMG_Data} !== exp_seq[n-4]) begin
        fails++; $display("FAIL d0_slot_c%0d: got %h/%h expected %h", n, Scan_Sig, SMG_Data, exp_seq[n-4]);
      end
    end
    goto(10);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hD_B0) begin fails++; $display("FAIL d1_3: got %h/%h expected d/b0", Scan_Sig, SMG_Data); end
    goto(16);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hB_A4) begin fails++; $display("FAIL d2_2: got %h/%h expected b/a4", Scan_Sig, SMG_Data); end
    goto(22);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'h7_F9) begin fails++; $display("FAIL d3_1: got %h/%h expected 7/f9", Scan_Sig, SMG_Data); end
    goto(26);
    checks++; if (Frame_Done !== 1'b0) begin fails++; $display("FAIL frame_early: got %b expected 0", Frame_Done); end
    goto(27);
    checks++; if (Frame_Done !== 1'b1) begin fails++; $display("FAIL frame_pulse1: got %b expected 1", Frame_Done); end
    goto(28);
    checks++; if (Frame_Done !== 1'b0) begin fails++; $display("FAIL frame_late: got %b expected 0", Frame_Done); end
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hE_99) begin fails++; $display("FAIL frame2_d0: got %h/%h expected e/99", Scan_Sig, SMG_Data); end
    goto(51);
    checks++; if (Frame_Done !== 1'b1) begin fails++; $display("FAIL frame_pulse2: got %b expected 1", Frame_Done); end
  endtask

  task automatic test_blanking();
    do_reset(16'h0050, 4'b0100, 1'b1, 1'b1);
    goto(4);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hE_C0) begin fails++; $display("FAIL blz_d0: got %h/%h expected e/c0", Scan_Sig, SMG_Data); end
    goto(10);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hD_92) begin fails++; $display("FAIL blz_d1: got %h/%h expected d/92", Scan_Sig, SMG_Data); end
    goto(16);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hB_7F) begin fails++; $display("FAIL blz_d2_dp: got %h/%h expected b/7f", Scan_Sig, SMG_Data); end
    goto(22);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'h7_FF) begin fails++; $display("FAIL blz_d3: got %h/%h expected 7/ff", Scan_Sig, SMG_Data); end
  endtask

  task automatic test_tear_free();
    do_reset(16'h1234, 4'b0000, 1'b0, 1'b1);
    goto(17);
    Number_Sig = 16'hAAAA;
    Load       = 1'b1;
    goto(18);
    Load = 1'b0;
    goto(22);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'h7_F9) begin fails++; $display("FAIL tear_d3_old: got %h/%h expected 7/f9", Scan_Sig, SMG_Data); end
    goto(28);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hE_88) begin fails++; $display("FAIL tear_d0_new: got %h/%h expected e/88", Scan_Sig, SMG_Data); end
    goto(34);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hD_88) begin fails++; $display("FAIL tear_d1_new: got %h/%h expected d/88", Scan_Sig, SMG_Data); end
    // Load raised on the very cycle the frame boundary is crossed.
    goto(51);
    Number_Sig = 16'h0005;
    Load       = 1'b1;
    goto(52);
    Load = 1'b0;
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hE_92) begin fails++; $display("FAIL boundary_load: got %h/%h expected e/92", Scan_Sig, SMG_Data); end
    goto(58);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hD_C0) begin fails++; $display("FAIL boundary_d1: got %h/%h expected d/c0", Scan_Sig, SMG_Data); end
  endtask

  task automatic test_step_tick();
    logic exp;
    do_reset(16'h0000, 4'b0000, 1'b0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      goto(n);
      exp = (n == 4 || n == 9 || n == 14);
      checks++;
      if (Step_Tick !== exp) begin fails++; $display("FAIL step_tick_c%0d: got %b expected %b", n, Step_Tick, exp); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(16'h0000, 4'b0000, 1'b0, 1'b0);
    goto(11);
    Number_Sig = 16'h8888;
    Load       = 1'b1;
    goto(12);
    Load = 1'b0;
    goto(13);
    checks++; if (Scan_Sig !== 4'hD) begin fails++; $display("FAIL mid_pre_d1: got %h expected d", Scan_Sig); end
    RSTn = 1'b0;
    #1;
    checks++;
    if ({Scan_Sig, SMG_Data, Frame_Done, Step_Tick} !== 14'b1111_11111111_0_0) begin
      fails++; $display("FAIL mid_async: got %h/%h/%b/%b expected f/ff/0/0", Scan_Sig, SMG_Data, Frame_Done, Step_Tick);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    goto(3);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hF_FF) begin fails++; $display("FAIL mid_rst_wait: got %h/%h expected f/ff", Scan_Sig, SMG_Data); end
    goto(4);
    checks++; if ({Scan_Sig, SMG_Data} !== 12'hE_C0) begin fails++; $display("FAIL mid_load_lost: got %h/%h expected e/c0", Scan_Sig, SMG_Data); end
  endtask

  initial begin
    test_reset();
    test_display_1234();
    test_blanking();
    test_tear_free();
    test_step_tick();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
